// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-port round-robin arbiter for the shared UART transmit byte stream
// Locked multi-byte grants, burst cap, idle-lock timeout and per-port debug byte counters.
module uart_tx_arbiter #(
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    input  logic        req0_lock,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    input  logic        req1_lock,
    output logic        req1_ready,
    output logic        uart_out_valid,
    output logic [7:0]  uart_out_data,
    input  logic        uart_out_ready,
    output logic [1:0]  grant,
    output logic        lock_timeout,
    output logic [31:0] byte_count0,
    output logic [31:0] byte_count1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [8:0]  BURST_LAST = 9'(MAX_BURST);
    localparam logic [15:0] IDLE_LAST  = 16'(LOCK_TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic        last_served;
    logic [7:0]  burst_cnt;
    logic [15:0] idle_cnt;

    logic        own_valid;
    logic        own_lock;
    logic        xfer;
    logic        burst_done;
    logic        do_release;
    logic        do_timeout;

    always_comb begin
        state_next     = state;
        own_valid      = 1'b0;
        own_lock       = 1'b0;
        uart_out_valid = 1'b0;
        uart_out_data  = 8'h00;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        xfer           = 1'b0;
        burst_done     = 1'b0;
        do_release     = 1'b0;
        do_timeout     = 1'b0;

        case (state)
            IDLE: begin
                // On a tie, last_served=1 favours port 0 and vice versa.
                if (req0_valid && (!req1_valid || last_served)) begin
                    state_next = GRANT0;
                end else if (req1_valid) begin
                    state_next = GRANT1;
                end
            end
            GRANT0: begin
                own_valid      = req0_valid;
                own_lock       = req0_lock;
                uart_out_valid = req0_valid;
                uart_out_data  = req0_data;
                req0_ready     = uart_out_ready;
            end
            GRANT1: begin
                own_valid      = req1_valid;
                own_lock       = req1_lock;
                uart_out_valid = req1_valid;
                uart_out_data  = req1_data;
                req1_ready     = uart_out_ready;
            end
            default: state_next = IDLE;
        endcase

        xfer       = uart_out_valid && uart_out_ready;
        burst_done = ({1'b0, burst_cnt} + 9'd1) == BURST_LAST;

        if (state != IDLE) begin
            if (xfer && (!own_lock || burst_done)) begin
                do_release = 1'b1;
            end else if (!own_valid && !own_lock) begin
                do_release = 1'b1;
            end else if (!own_valid && own_lock && idle_cnt == IDLE_LAST) begin
                do_release = 1'b1;
                do_timeout = 1'b1;
            end
        end

        if (do_release) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_served  <= 1'b1;
            burst_cnt    <= 8'd0;
            idle_cnt     <= 16'd0;
            lock_timeout <= 1'b0;
            byte_count0  <= 32'd0;
            byte_count1  <= 32'd0;
        end else begin
            state <= state_next;

            if (xfer && state == GRANT0) begin
                byte_count0 <= byte_count0 + 32'd1;
            end
            if (xfer && state == GRANT1) begin
                byte_count1 <= byte_count1 + 32'd1;
            end

            if (do_release) begin
                last_served <= (state == GRANT1);
                burst_cnt   <= 8'd0;
                idle_cnt    <= 16'd0;
            end else if (xfer) begin
                burst_cnt <= burst_cnt + 8'd1;
                idle_cnt  <= 16'd0;
            end else if (state != IDLE && !own_valid && own_lock) begin
                // A stalled valid byte never ages the lock; only empty cycles do.
                idle_cnt <= idle_cnt + 16'd1;
            end

            if (do_timeout) begin
                lock_timeout <= 1'b1;
            end
        end
    end

    assign grant = {state == GRANT1, state == GRANT0};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [7:0]  req0_data;
    logic        req0_lock;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_data;
    logic        req1_lock;
    logic        req1_ready;
    logic        uart_out_valid;
    logic [7:0]  uart_out_data;
    logic        uart_out_ready;
    logic [1:0]  grant;
    logic        lock_timeout;
    logic [31:0] byte_count0;
    logic [31:0] byte_count1;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx_arbiter #(
        .MAX_BURST    (16),
        .LOCK_TIMEOUT (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req0_valid     (req0_valid),
        .req0_data      (req0_data),
        .req0_lock      (req0_lock),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_data      (req1_data),
        .req1_lock      (req1_lock),
        .req1_ready     (req1_ready),
        .uart_out_valid (uart_out_valid),
        .uart_out_data  (uart_out_data),
        .uart_out_ready (uart_out_ready),
        .grant          (grant),
        .lock_timeout   (lock_timeout),
        .byte_count0    (byte_count0),
        .byte_count1    (byte_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [7:0]  d0;
        logic        l0;
        logic        v1;
        logic [7:0]  d1;
        logic        l1;
        logic        rdy;
        logic [1:0]  g;
        logic        uv;
        logic [7:0]  ud;
        logic        r0;
        logic        r1;
        logic [31:0] c0;
        logic [31:0] c1;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_data = 8'h00; req0_lock = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_lock = 1'b0;
        uart_out_ready = 1'b1;
    endtask

    // Leaves the bench at a negedge with reset low and the arbiter in IDLE.
    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p1, nx, bad;
        int          exp_port[21];
        int          exp_cyc[21];
        logic [7:0]  exp_dat[21];
        logic [1:0]  g_exp;

        //            rst v0 d0    l0 v1 d1    l1 rdy  g     uv ud    r0 r1 c0 c1
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 32'd0, 32'd0};
        vecs[1] = '{1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 32'd0, 32'd0};
        vecs[2] = '{1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b1, 8'h41, 1'b1, 1'b0, 32'd0, 32'd0};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 32'd1, 32'd0};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 32'd1, 32'd0};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 2'b10, 1'b1, 8'h22, 1'b0, 1'b0, 32'd1, 32'd0};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 2'b10, 1'b1, 8'h22, 1'b0, 1'b1, 32'd1, 32'd0};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 2'b10, 1'b0, 8'h22, 1'b0, 1'b1, 32'd1, 32'd1};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 2'b10, 1'b0, 8'h22, 1'b0, 1'b1, 32'd1, 32'd1};
        vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 32'd1, 32'd1};

        for (int i = 0; i < 21; i++) begin
            if (i < 16) begin
                exp_port[i] = 1; exp_cyc[i] = i + 1;  exp_dat[i] = 8'(8'h10 + i);
            end else if (i == 16) begin
                exp_port[i] = 0; exp_cyc[i] = 18;     exp_dat[i] = 8'hC3;
            end else begin
                exp_port[i] = 1; exp_cyc[i] = i + 3;  exp_dat[i] = 8'(8'h10 + i - 1);
            end
        end

        // Table: single byte on port 0, then a locked port 1 byte released by dropping lock.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            reset          = vecs[i].rst;
            req0_valid     = vecs[i].v0;
            req0_data      = vecs[i].d0;
            req0_lock      = vecs[i].l0;
            req1_valid     = vecs[i].v1;
            req1_data      = vecs[i].d1;
            req1_lock      = vecs[i].l1;
            uart_out_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].g));
            chk($sformatf("vec%0d_uvalid", i), 32'(uart_out_valid), 32'(vecs[i].uv));
            chk($sformatf("vec%0d_udata", i), 32'(uart_out_data), 32'(vecs[i].ud));
            chk($sformatf("vec%0d_ready0", i), 32'(req0_ready), 32'(vecs[i].r0));
            chk($sformatf("vec%0d_ready1", i), 32'(req1_ready), 32'(vecs[i].r1));
            chk($sformatf("vec%0d_cnt0", i), byte_count0, vecs[i].c0);
            chk($sformatf("vec%0d_cnt1", i), byte_count1, vecs[i].c1);
            chk($sformatf("vec%0d_lock_to", i), 32'(lock_timeout), 32'd0);
            @(negedge clk);
        end

        // Round-robin with both ports always valid: 00,01,00,10 repeating.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hA0;
        req1_valid = 1'b1; req1_data = 8'hB0;
        for (int k = 0; k < 40; k++) begin
            #1;
            case (k % 4)
                1:       g_exp = 2'b01;
                3:       g_exp = 2'b10;
                default: g_exp = 2'b00;
            endcase
            chk($sformatf("rr_grant_c%0d", k), 32'(grant), 32'(g_exp));
            @(negedge clk);
        end
        #1;
        chk("rr_cnt0", byte_count0, 32'd10);
        chk("rr_cnt1", byte_count1, 32'd10);

        // Locked 20-byte stream on port 1 cut at 16, port 0 gets its byte in between.
        do_reset();
        p0 = 0; p1 = 0; nx = 0;
        for (int c = 0; c < 40; c++) begin
            req1_valid = (p1 < 20);
            req1_data  = 8'(8'h10 + p1);
            req1_lock  = (p1 < 19);
            req0_valid = (c >= 1) && (p0 < 1);
            req0_data  = 8'hC3;
            req0_lock  = 1'b0;
            #1;
            if (c == 17) chk("burst_gap_idle", 32'(grant), 32'd0);
            if (uart_out_valid && uart_out_ready) begin
                if (nx < 21) begin
                    chk($sformatf("burst_port_x%0d", nx), 32'(req1_ready), 32'(exp_port[nx]));
                    chk($sformatf("burst_cyc_x%0d", nx), 32'(c), 32'(exp_cyc[nx]));
                    chk($sformatf("burst_data_x%0d", nx), 32'(uart_out_data), 32'(exp_dat[nx]));
                end
                if (req1_ready) p1++;
                else            p0++;
                nx++;
            end
            @(negedge clk);
        end
        chk("burst_xfers", 32'(nx), 32'd21);

        // Idle lock on port 0 times out after 8 empty cycles; then reset mid-burst on port 1.
        do_reset();
        for (int c = 0; c < 15; c++) begin
            req0_valid = (c < 2);
            req0_data  = 8'h77;
            req0_lock  = 1'b1;
            req1_valid = 1'b1;
            req1_data  = 8'h88;
            req1_lock  = 1'b1;
            reset      = (c == 14);
            #1;
            if (c == 1) chk("to_grant0", 32'(grant), 32'b01);
            if (c == 8) chk("to_flag_c8", 32'(lock_timeout), 32'd0);
            if (c == 9) begin
                chk("to_hold_c9", 32'(grant), 32'b01);
                chk("to_flag_c9", 32'(lock_timeout), 32'd0);
            end
            if (c == 10) begin
                chk("to_idle_c10", 32'(grant), 32'b00);
                chk("to_flag_c10", 32'(lock_timeout), 32'd1);
            end
            if (c == 11) chk("to_grant1_c11", 32'(grant), 32'b10);
            if (c == 14) begin
                chk("pre_rst_flag", 32'(lock_timeout), 32'd1);
                chk("pre_rst_cnt0", byte_count0, 32'd1);
                chk("pre_rst_cnt1", byte_count1, 32'd3);
                chk("pre_rst_grant", 32'(grant), 32'b10);
            end
            @(negedge clk);
        end
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_uvalid", 32'(uart_out_valid), 32'd0);
        chk("rst_cnt0", byte_count0, 32'd0);
        chk("rst_cnt1", byte_count1, 32'd0);
        chk("rst_flag", 32'(lock_timeout), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Output stalled for 100 cycles with a valid port 1 byte: grant and data must hold.
        do_reset();
        uart_out_ready = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h5A; req1_lock = 1'b0;
        #1;
        chk("stall_c0_idle", 32'(grant), 32'd0);
        @(negedge clk);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (grant !== 2'b10 || uart_out_data !== 8'h5A || uart_out_valid !== 1'b1 || req1_ready !== 1'b0)
                bad++;
            @(negedge clk);
        end
        chk("stall_hold_bad_cycles", 32'(bad), 32'd0);
        uart_out_ready = 1'b1;
        #1;
        chk("stall_release_ready", 32'(req1_ready), 32'd1);
        chk("stall_release_data", 32'(uart_out_data), 32'h5A);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        chk("stall_after_grant", 32'(grant), 32'd0);
        chk("stall_after_cnt1", byte_count1, 32'd1);
        chk("stall_after_flag", 32'(lock_timeout), 32'd0);

        // Counter wrap from all-ones.
        do_reset();
        force dut.byte_count0 = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.byte_count0;
        req0_valid = 1'b1; req0_data = 8'h01; req0_lock = 1'b0;
        @(negedge clk);
        #1;
        chk("wrap_grant0", 32'(grant), 32'b01);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("wrap_cnt0", byte_count0, 32'd0);
        chk("wrap_cnt1", byte_count1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit byte stream (valid/data/ready) between two requesters: port 0 is the program loader (status/ack bytes) and port 1 is the core.
- Replaces the current OR of the two valid lines. Only one requester drives the stream at a time.
- Supports multi-byte messages via a lock input, a burst limit, an idle-lock timeout and per-port byte counters for debug.

Parameters:
- MAX_BURST, 16, maximum bytes transferred per grant before a forced re-arbitration. Range 1..255.
- LOCK_TIMEOUT, 1024, cycles a locked but idle grantee may hold the grant. Range 1..2^16-1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  port 0 byte valid
- req0_data  input  8  port 0 byte
- req0_lock  input  1  port 0 requests to keep the grant after the current byte
- req0_ready  output  1  port 0 byte accepted this cycle
- req1_valid  input  1  port 1 byte valid
- req1_data  input  8  port 1 byte
- req1_lock  input  1  port 1 requests to keep the grant after the current byte
- req1_ready  output  1  port 1 byte accepted this cycle
- uart_out_valid  output  1  to UART transmit buffer
- uart_out_data  output  8  to UART transmit buffer
- uart_out_ready  input  1  from UART; buffer can take a byte
- grant  output  2  one-hot current owner; 00 when idle
- lock_timeout  output  1  sticky; set when a lock was broken by timeout
- byte_count0  output  32  bytes transferred from port 0, wraps at 2^32
- byte_count1  output  32  bytes transferred from port 1, wraps at 2^32

Behaviour:
- One clock domain. Reset is synchronous and active-high. Every register takes its reset value on any posedge clk with reset=1, including mid-transfer.
- Reset values:
  - state=IDLE, grant=00
  - last_served=1, so port 0 wins the first tie
  - burst_cnt=0, idle_cnt=0
  - lock_timeout=0, byte_count0=0, byte_count1=0
  - uart_out_valid=0, req0_ready=0, req1_ready=0
- Transfer definition: a transfer occurs on a cycle with uart_out_valid && uart_out_ready.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - Outputs: uart_out_valid=0, both readies 0, uart_out_data=0.
  - Only req0_valid: next state GRANT0.
  - Only req1_valid: next state GRANT1.
  - Both valid: grant the port != last_served (round-robin).
  - Neither valid: stay in IDLE.
  - Arbitration latency is exactly 1 cycle. A byte presented in IDLE can transfer at the earliest on the following cycle.
- GRANTn, combinational pass-through of the owner:
  - uart_out_valid=reqn_valid
  - uart_out_data=reqn_data
  - reqn_ready=uart_out_ready
  - The other port's ready is 0.
- On each transfer in GRANTn:
  - byte_countn is incremented.
  - burst_cnt is incremented.
  - idle_cnt is cleared.
- Release from GRANTn, evaluated at the clock edge; next state is IDLE, last_served<=n, burst_cnt<=0, idle_cnt<=0:
  - (a) A transfer occurs with reqn_lock=0.
  - (b) A transfer occurs and burst_cnt+1 == MAX_BURST, regardless of lock.
  - (c) reqn_valid=0 and reqn_lock=0, with no transfer.
  - (d) reqn_lock=1, reqn_valid=0 and idle_cnt == LOCK_TIMEOUT-1. This also sets lock_timeout<=1.
- Otherwise, if reqn_valid=0 and reqn_lock=1, idle_cnt increments.
- There is no IDLE bypass: after a release the arbiter spends one cycle in IDLE, so the maximum throughput per grant is MAX_BURST bytes per MAX_BURST+1 cycles.
- A valid byte stalled by uart_out_ready=0 holds the grant indefinitely. This is not a timeout; idle_cnt counts only cycles with valid low.
- Requesters must hold data stable while valid && !ready, per the standard handshake. The arbiter does not buffer.
- grant is the registered state decode: GRANT0 -> 01, GRANT1 -> 10, IDLE -> 00. 11 never occurs.
- lock_timeout clears only on reset.
- Counters are 32-bit unsigned and wrap from 0xFFFFFFFF to 0.

Test Plan:
- Reset, then req0_valid=1 with data 0x41, lock=0, ready=1:
  - grant=01 one cycle later.
  - Byte 0x41 is transferred on that cycle.
  - IDLE follows.
  - byte_count0=1.
- Both ports valid continuously, lock=0, ready=1:
  - Grants alternate 01,00,10,00,01…
  - Port 0 is served first.
  - After 10 bytes from each port, byte_count0=byte_count1=10.
- Port 1 locked streaming 20 bytes with MAX_BURST=16, port 0 waiting:
  - Port 1 sends 16 bytes.
  - Grant goes to IDLE, then to port 0.
  - Port 1's remaining 4 bytes follow after port 0's release.
- Port 0 lock=1 with valid dropped, LOCK_TIMEOUT=8, port 1 valid:
  - After 8 idle cycles, grant is released.
  - lock_timeout=1.
  - Port 1 is granted on the next cycle.
- uart_out_ready=0 for 100 cycles while port 1 holds a valid byte 0x5A:
  - No timeout, grant stays 10, data stays 0x5A.
  - The byte transfers on the first ready=1 cycle.
- reset asserted mid-burst in GRANT1 with counters non-zero:
  - The next cycle shows grant=00, all readies 0, counters 0, lock_timeout=0.
- byte_count0 preset to 0xFFFFFFFF via a force:
  - One transfer wraps the counter to 0.
